// File: rtl/imem_pkg.sv
// Shared types and constants for the loadable instruction memory.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } imem_state_e;

  // addi x0,x0,0
  localparam logic [31:0] IMEM_NOP = 32'h0000_0013;

endpackage

// File: rtl/imem_loader_if.sv
// Programming and fetch ports of imem_loader grouped as one bundle.
interface imem_loader_if #(
  parameter int DEPTH = 1024
);
  localparam int AW = $clog2(DEPTH);

  logic          prog_en;
  logic          prog_valid;
  logic [31:0]   prog_data;
  logic          prog_ready;
  logic [AW:0]   prog_count;
  logic          prog_full;
  logic          req_valid;
  logic [31:0]   A;
  logic          req_ready;
  logic          rsp_valid;
  logic [31:0]   RD;
  logic          rsp_fault;
  logic          rsp_ready;

  modport slave (
    input  prog_en, prog_valid, prog_data, req_valid, A, rsp_ready,
    output prog_ready, prog_count, prog_full, req_ready, rsp_valid, RD, rsp_fault
  );

  modport master (
    output prog_en, prog_valid, prog_data, req_valid, A, rsp_ready,
    input  prog_ready, prog_count, prog_full, req_ready, rsp_valid, RD, rsp_fault
  );
endinterface

// File: rtl/imem_ram_1r1w.sv
// Simple dual-port word array: one synchronous write, one synchronous read, no reset.
module imem_ram_1r1w #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // read port; output holds when re is low so a stalled response stays stable
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loadable instruction memory: programming stream in, valid/ready fetch with
// a one-cycle registered response that returns a NOP on faulting fetches.
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  imem_state_e state_r;
  imem_state_e state_s;
  logic        load_entry_s;

  logic [AW:0]   count_r;
  logic          full_s;
  logic          prog_ready_s;
  logic          wr_en_s;

  logic          req_ready_s;
  logic          req_fire_s;
  logic [AW-1:0] idx_s;
  logic          fault_s;
  logic          rd_en_s;

  logic          rsp_valid_r;
  logic          rsp_fault_r;
  logic          rsp_ram_r;
  logic [31:0]   ram_q_s;

  // next-state logic; any entry into LOAD restarts the load
  always_comb begin
    state_s      = state_r;
    load_entry_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.prog_en) begin
          state_s      = LOAD;
          load_entry_s = 1'b1;
        end else begin
          state_s      = IDLE;
        end
      end
      LOAD: begin
        if (!bus.prog_en) begin
          state_s = RUN;
        end else begin
          state_s = LOAD;
        end
      end
      RUN: begin
        if (bus.prog_en) begin
          state_s      = LOAD;
          load_entry_s = 1'b1;
        end else begin
          state_s      = RUN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // handshakes and fetch fault classification
  always_comb begin
    full_s       = (count_r == FULL_COUNT);
    prog_ready_s = (state_r == LOAD) && !full_s;
    wr_en_s      = bus.prog_valid && prog_ready_s;
    req_ready_s  = (state_r == RUN) && (!rsp_valid_r || bus.rsp_ready);
    req_fire_s   = bus.req_valid && req_ready_s;
    idx_s        = bus.A[AW+1:2];
    // only words below the loaded count are valid fetch targets
    fault_s      = (bus.A[1:0] != 2'b00)
                || ((bus.A >> (AW+2)) != 32'd0)
                || ({1'b0, idx_s} >= count_r);
    rd_en_s      = req_fire_s && !fault_s;
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // load counter doubles as the write pointer; it saturates at DEPTH
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= '0;
    end else if (load_entry_s) begin
      count_r <= '0;
    end else if (wr_en_s) begin
      count_r <= count_r + (AW+1)'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // response register; a restart into LOAD drops any pending response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid_r <= 1'b0;
      rsp_fault_r <= 1'b0;
      rsp_ram_r   <= 1'b0;
    end else if (load_entry_s) begin
      rsp_valid_r <= 1'b0;
    end else if (req_fire_s) begin
      rsp_valid_r <= 1'b1;
      rsp_fault_r <= fault_s;
      rsp_ram_r   <= !fault_s;
    end else if (rsp_valid_r && bus.rsp_ready) begin
      rsp_valid_r <= 1'b0;
    end else begin
      rsp_valid_r <= rsp_valid_r;
    end
  end

  imem_ram_1r1w #(
    .DEPTH (DEPTH),
    .WIDTH (32),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en_s),
    .waddr (count_r[AW-1:0]),
    .wdata (bus.prog_data),
    .re    (rd_en_s),
    .raddr (idx_s),
    .rdata (ram_q_s)
  );

  assign bus.prog_ready = prog_ready_s;
  assign bus.prog_count = count_r;
  assign bus.prog_full  = full_s;
  assign bus.req_ready  = req_ready_s;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_fault  = rsp_fault_r;
  assign bus.RD         = rsp_ram_r ? ram_q_s : IMEM_NOP;

endmodule

// File: tb/tb_imem_loader.sv
// Directed plus randomized bench for imem_loader against a queue-based model.
module tb_imem_loader;
  import imem_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_loader_if #(.DEPTH(1024)) bus ();
  imem_loader_if #(.DEPTH(4))    bus4 ();

  imem_loader #(.DEPTH(1024)) dut  (.clk(clk), .reset(reset), .bus(bus));
  imem_loader #(.DEPTH(4))    dut4 (.clk(clk), .reset(reset), .bus(bus4));

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mq[$];
  logic [31:0] src[$];
  bit          pend;
  logic [31:0] pend_rd;
  bit          pend_f;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_fault(input logic [31:0] a);
    logic [31:0] sz;
    sz = mq.size();
    return (a[1:0] != 2'b00) || ((a >> 2) >= sz);
  endfunction

  function automatic logic [31:0] m_rd(input logic [31:0] a);
    if (m_fault(a)) return IMEM_NOP;
    return mq[a >> 2];
  endfunction

  function automatic logic [31:0] pick_addr();
    int k;
    k = $urandom_range(0, 7);
    case (k)
      0, 1, 2, 3, 4: return 32'($urandom_range(0, mq.size() + 1)) << 2;
      5:             return (32'($urandom_range(0, mq.size())) << 2) | 32'($urandom_range(1, 3));
      6:             return 32'd1 << $urandom_range(12, 31);
      default:       return $urandom();
    endcase
  endfunction

  task automatic load_main();
    @(negedge clk);
    bus.prog_en = 1'b1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    mq.delete();
    foreach (src[i]) begin
      @(negedge clk);
      bus.prog_valid = 1'b1;
      bus.prog_data = src[i];
      #1;
      chk("load.prog_ready", bus.prog_ready, 32'd1);
      mq.push_back(src[i]);
      @(posedge clk);
    end
    @(negedge clk);
    bus.prog_valid = 1'b0;
    bus.prog_en = 1'b0;
    @(posedge clk);
    pend = 1'b0;
  endtask

  task automatic fetch1(input logic [31:0] a, input string tag);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.A = a;
    bus.rsp_ready = 1'b1;
    #1;
    chk({tag, ".req_ready"}, bus.req_ready, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    chk({tag, ".rsp_valid"}, bus.rsp_valid, 32'd1);
    chk({tag, ".RD"}, bus.RD, m_rd(a));
    chk({tag, ".rsp_fault"}, bus.rsp_fault, 32'(m_fault(a)));
    @(posedge clk);
  endtask

  initial begin
    logic [31:0] w4 [5];
    logic [31:0] a4 [3];
    bit          rv;
    bit          exp_rdy;
    int          n;

    w4 = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004, 32'h5555_0005};
    a4 = '{32'd0, 32'd12, 32'd16};
    reset = 1'b0;
    bus.prog_en = 1'b0;  bus.prog_valid = 1'b0;  bus.prog_data = 32'd0;
    bus.req_valid = 1'b0; bus.A = 32'd0;          bus.rsp_ready = 1'b0;
    bus4.prog_en = 1'b0; bus4.prog_valid = 1'b0; bus4.prog_data = 32'd0;
    bus4.req_valid = 1'b0; bus4.A = 32'd0;        bus4.rsp_ready = 1'b0;
    pend = 1'b0;

    // reset values
    #12;
    chk("rst.prog_count", bus.prog_count, 32'd0);
    chk("rst.prog_full",  bus.prog_full,  32'd0);
    chk("rst.prog_ready", bus.prog_ready, 32'd0);
    chk("rst.req_ready",  bus.req_ready,  32'd0);
    chk("rst.rsp_valid",  bus.rsp_valid,  32'd0);
    chk("rst.RD",         bus.RD,         IMEM_NOP);
    chk("rst.rsp_fault",  bus.rsp_fault,  32'd0);
    @(negedge clk);
    reset = 1'b1;

    // fetch in IDLE is ignored
    @(negedge clk);
    bus.req_valid = 1'b1; bus.A = 32'd0; bus.rsp_ready = 1'b1;
    #1;
    chk("idle.req_ready", bus.req_ready, 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    chk("idle.rsp_valid", bus.rsp_valid, 32'd0);

    // load four words and fetch them back-to-back
    src = '{32'h00200293, 32'h04000313, 32'h00532423, 32'h00832383};
    load_main();
    @(negedge clk);
    #1;
    chk("load.prog_count", bus.prog_count, 32'd4);
    chk("load.prog_full",  bus.prog_full,  32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.req_valid = 1'b1; bus.A = 32'(4 * i); bus.rsp_ready = 1'b1;
      #1;
      chk("b2b.req_ready", bus.req_ready, 32'd1);
      if (i > 0) begin
        chk("b2b.rsp_valid", bus.rsp_valid, 32'd1);
        chk("b2b.RD",        bus.RD,        src[i-1]);
        chk("b2b.rsp_fault", bus.rsp_fault, 32'd0);
      end
      @(posedge clk);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    chk("b2b.last.rsp_valid", bus.rsp_valid, 32'd1);
    chk("b2b.last.RD",        bus.RD,        src[3]);
    @(posedge clk);

    // faults
    fetch1(32'h0000_0002, "f.misalign");
    fetch1(32'd16,        "f.unloaded");
    fetch1(32'h1000_0000, "f.high");

    // backpressure
    @(negedge clk);
    bus.req_valid = 1'b1; bus.A = 32'd4; bus.rsp_ready = 1'b1;
    #1;
    chk("bp.req_ready0", bus.req_ready, 32'd1);
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.rsp_ready = 1'b0; bus.A = 32'd8;
      #1;
      chk("bp.rsp_valid", bus.rsp_valid, 32'd1);
      chk("bp.RD",        bus.RD,        32'h04000313);
      chk("bp.req_ready", bus.req_ready, 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    bus.req_valid = 1'b0; bus.rsp_ready = 1'b1;
    #1;
    chk("bp.RD.release", bus.RD, 32'h04000313);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("bp.drained", bus.rsp_valid, 32'd0);

    // reload with a pending response
    @(negedge clk);
    bus.req_valid = 1'b1; bus.A = 32'd0; bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0; bus.prog_en = 1'b1;
    #1;
    chk("rl.pending", bus.rsp_valid, 32'd1);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rl.rsp_valid",  bus.rsp_valid,  32'd0);
    chk("rl.prog_count", bus.prog_count, 32'd0);
    src = '{32'h00100093};
    load_main();
    fetch1(32'd0, "rl.word0");
    fetch1(32'd4, "rl.word1");

    // overflow on the 4-deep instance
    @(negedge clk);
    bus4.prog_en = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus4.prog_valid = 1'b1; bus4.prog_data = w4[i];
      #1;
      chk("ovf.prog_ready", bus4.prog_ready, 32'(i < 4));
      @(posedge clk);
    end
    @(negedge clk);
    bus4.prog_valid = 1'b0; bus4.prog_en = 1'b0;
    #1;
    chk("ovf.prog_full",  bus4.prog_full,  32'd1);
    chk("ovf.prog_count", bus4.prog_count, 32'd4);
    @(posedge clk);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      bus4.req_valid = 1'b1; bus4.A = a4[j]; bus4.rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus4.req_valid = 1'b0;
      #1;
      chk("ovf.rsp_valid", bus4.rsp_valid, 32'd1);
      chk("ovf.RD",        bus4.RD,        (j < 2) ? w4[a4[j] >> 2] : IMEM_NOP);
      chk("ovf.rsp_fault", bus4.rsp_fault, 32'(j == 2));
      @(posedge clk);
    end

    // randomized traffic against the model
    for (int r = 0; r < 3; r++) begin
      src.delete();
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) src.push_back($urandom());
      load_main();
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        rv = 1'($urandom_range(0, 1));
        bus.req_valid = rv;
        bus.A = pick_addr();
        bus.rsp_ready = ($urandom_range(0, 3) != 0);
        #1;
        chk("rnd.rsp_valid", bus.rsp_valid, 32'(pend));
        if (pend) begin
          chk("rnd.RD",        bus.RD,        pend_rd);
          chk("rnd.rsp_fault", bus.rsp_fault, 32'(pend_f));
        end
        exp_rdy = !pend || bus.rsp_ready;
        chk("rnd.req_ready", bus.req_ready, 32'(exp_rdy));
        if (pend && bus.rsp_ready) pend = 1'b0;
        if (rv && exp_rdy) begin
          pend    = 1'b1;
          pend_rd = m_rd(bus.A);
          pend_f  = m_fault(bus.A);
        end
        @(posedge clk);
      end
      @(negedge clk);
      bus.req_valid = 1'b0; bus.rsp_ready = 1'b1;
      @(posedge clk);
      pend = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Parametrised, loadable instruction memory for the single-cycle RISC-V core. It replaces the fixed, preinitialised instruction store with a 1R1W word array and a programming port. The programming port streams words in at an auto-incrementing pointer. The fetch port uses a valid/ready request with a registered response. Fetches that are misaligned or target unloaded words return a NOP and raise a fault flag.

## Interface
Parameters:
- DEPTH, 1024: number of 32-bit words. Must be a power of 2, ≥ 2.
- AW, $clog2(DEPTH): word-index width (derived, not overridden).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- prog_en  in  1  level; 1 requests programming mode.
- prog_valid  in  1  programming word valid.
- prog_data  in  32  programming word.
- prog_ready  out  1  programming word accepted this cycle when prog_valid is also 1.
- prog_count  out  AW+1  number of words loaded since the last load start.
- prog_full  out  1  prog_count == DEPTH.
- req_valid  in  1  fetch request valid.
- A  in  32  fetch byte address.
- req_ready  out  1  fetch request accepted when req_valid is also 1.
- rsp_valid  out  1  response valid.
- RD  out  32  fetched instruction.
- rsp_fault  out  1  response is a fault (qualified by rsp_valid).
- rsp_ready  in  1  consumer takes the response.

## Operation
- FSM states are IDLE, LOAD and RUN. Reset enters IDLE.
  - IDLE: prog_en=1 goes to LOAD.
  - LOAD: prog_en=0 goes to RUN.
  - RUN: prog_en=1 goes to LOAD.
  - Every entry to LOAD clears the pointer and prog_count to 0 and clears rsp_valid, which flushes any pending response.
- LOAD behaviour:
  - prog_ready = (state==LOAD) && !prog_full.
  - On prog_valid && prog_ready: mem[ptr] ← prog_data, then ptr and prog_count both increment.
  - When full, extra words are dropped and the pointer does not wrap.
- RUN behaviour:
  - req_ready = (state==RUN) && (!rsp_valid || rsp_ready).
  - Accepted request: the word index is A[AW+1:2].
  - Fault when A[1:0]≠0, or A[31:AW+2]≠0, or index ≥ prog_count.
  - Fault response: RD=32'h0000_0013 (addi x0,x0,0) and rsp_fault=1.
  - Otherwise: RD=mem[index] and rsp_fault=0.
- The response register holds while rsp_valid && !rsp_ready.
- Memory contents are not reset. Because reset zeroes prog_count, every fetch after reset faults until a reload.

## Timing
- Reset values: state=IDLE, prog_count=0, prog_full=0, prog_ready=0, req_ready=0, rsp_valid=0, RD=32'h0000_0013, rsp_fault=0.
- Fetch latency is 1 cycle: a request accepted at edge n gives rsp_valid=1 after edge n.
- Back-to-back fetches sustain 1 per cycle while rsp_ready=1.
- A write at edge n is visible to a fetch accepted at edge n+2 or later. The LOAD→RUN transition guarantees this spacing.
- prog_en=1 while rsp_valid=1 and rsp_ready=1 in RUN: LOAD wins, the response is dropped and the consumer must refetch.
- prog_en toggling for a single cycle still performs a full restart: count cleared.
- Reset asserted mid-LOAD or mid-RUN: outputs take reset values immediately. Partial loads are discarded logically.
- req_valid in IDLE or LOAD is ignored; req_ready=0.

## Structure
- Shared package imem_pkg contains:
  - state enum imem_state_e {IDLE, LOAD, RUN};
  - constant IMEM_NOP = 32'h0000_0013.
- Sub-module imem_ram_1r1w (DEPTH, width 32): one synchronous write port and one synchronous read port, no reset, inferable as block RAM.
- Everything else (FSM, pointer, fault check, response register) lives in imem_loader.

## Test plan
- Reset: hold reset=0 → all outputs at reset values. Fetch A=0 after release (IDLE) → req_ready=0.
- Load and run:
  - Load 32'h00200293, 32'h04000313, 32'h00532423, 32'h00832383, then drop prog_en.
  - Check prog_count=4.
  - Fetch A=0,4,8,12 back-to-back → RD matches each word, rsp_fault=0, one response per cycle.
- Faults: after the above, A=32'h2 → fault with NOP. A=16 (unloaded) → fault with NOP. A=32'h1000_0000 → fault.
- Backpressure: hold rsp_ready=0 for 3 cycles after a fetch of A=4 → RD=32'h04000313 is stable, req_ready=0, and no second request is accepted.
- Overflow: with DEPTH=4, stream 5 words → prog_ready=0 on the 5th, prog_full=1, and mem[0] keeps the first word (no wrap).
- Reload mid-run: assert prog_en with a pending response → rsp_valid=0 next cycle and prog_count=0. Fetch A=0 after load of 1 word → new word returned, and A=4 faults.
